// File: rtl/queue_dispatcher_if.sv
// Downstream request channel: one data word qualified by a valid/ready handshake.
interface queue_dispatcher_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/queue_dispatcher.sv
// Moves one granted entry from a FWFT request queue to the memory port,
// releases the scheduler with a one-cycle consumed pulse, and keeps
// per-queue served/dropped statistics plus sticky protocol-error flags.
module queue_dispatcher #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int COUNTER_WIDTH    = 32,
  localparam int IDW             = $clog2(NUMBER_OF_QUEUES)
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      sched_enable_i,
  input  logic [IDW-1:0]                            sched_id_i,
  input  logic [NUMBER_OF_QUEUES-1:0]               empty_i,
  input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0]    queue_data_i,
  output logic [NUMBER_OF_QUEUES-1:0]               pop_o,
  queue_dispatcher_if.master                        mem_if,
  output logic                                      consumed_o,
  output logic                                      busy_o,
  input  logic                                      clear_stats_i,
  output logic [NUMBER_OF_QUEUES*COUNTER_WIDTH-1:0] served_count_o,
  output logic [NUMBER_OF_QUEUES*COUNTER_WIDTH-1:0] drop_count_o,
  output logic                                      overlap_error_o,
  output logic                                      drop_error_o
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, ACK} state_t;

  state_t                   state_q;
  logic [IDW-1:0]           cur_id_q;
  logic [DATA_WIDTH-1:0]    out_data_q;
  logic                     out_valid_q;
  logic                     consumed_q;
  logic                     overlap_error_q;
  logic                     drop_error_q;
  logic [COUNTER_WIDTH-1:0] served_q [NUMBER_OF_QUEUES];
  logic [COUNTER_WIDTH-1:0] drop_q   [NUMBER_OF_QUEUES];
  logic [DATA_WIDTH-1:0]    qdata    [NUMBER_OF_QUEUES];

  logic head_empty;
  logic accept;

  for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_lane
    assign qdata[g]                                        = queue_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign served_count_o[g*COUNTER_WIDTH +: COUNTER_WIDTH] = served_q[g];
    assign drop_count_o[g*COUNTER_WIDTH +: COUNTER_WIDTH]   = drop_q[g];
  end

  assign head_empty       = empty_i[cur_id_q];
  assign accept           = (state_q == SEND) && mem_if.out_ready;

  assign mem_if.out_data  = out_data_q;
  assign mem_if.out_valid = out_valid_q;
  assign consumed_o       = consumed_q;
  assign busy_o           = (state_q != IDLE);
  assign overlap_error_o  = overlap_error_q;
  assign drop_error_o     = drop_error_q;

  // Pop strobe: the empty check and the pop happen in the same FETCH cycle,
  // so the strobe is decoded from state rather than registered a cycle early.
  always_comb begin
    pop_o = '0;
    if ((state_q == FETCH) && !head_empty) begin
      pop_o[cur_id_q] = 1'b1;
    end
  end

  // Transfer sequencer with registered handshake and completion outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_id_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      consumed_q  <= 1'b0;
    end else begin
      consumed_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sched_enable_i) begin
            cur_id_q <= sched_id_i;
            state_q  <= FETCH;
          end
        end
        FETCH: begin
          if (!head_empty) begin
            out_data_q  <= qdata[cur_id_q];
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end else begin
            consumed_q <= 1'b1;
            state_q    <= ACK;
          end
        end
        SEND: begin
          if (mem_if.out_ready) begin
            out_valid_q <= 1'b0;
            consumed_q  <= 1'b1;
            state_q     <= ACK;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Saturating statistics and sticky error flags; clear beats any same-cycle event.
  always_ff @(posedge clock) begin
    if (reset || clear_stats_i) begin
      overlap_error_q <= 1'b0;
      drop_error_q    <= 1'b0;
      for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
        served_q[i] <= '0;
        drop_q[i]   <= '0;
      end
    end else begin
      if (sched_enable_i && (state_q != IDLE)) begin
        overlap_error_q <= 1'b1;
      end
      if ((state_q == FETCH) && head_empty) begin
        drop_error_q <= 1'b1;
      end
      for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
        if (accept && (cur_id_q == IDW'(i)) && (served_q[i] != '1)) begin
          served_q[i] <= served_q[i] + 1'b1;
        end
        if ((state_q == FETCH) && head_empty && (cur_id_q == IDW'(i)) && (drop_q[i] != '1)) begin
          drop_q[i] <= drop_q[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_queue_dispatcher.sv
// Directed self-checking bench for queue_dispatcher: basic transfer,
// backpressure, empty grant, overlapping grant, saturation/clear, reset mid-SEND.
module tb_queue_dispatcher;

  localparam int NQ = 4;
  localparam int DW = 16;
  localparam int CW = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            sched_enable;
  logic [1:0]      sched_id;
  logic [NQ-1:0]   empty;
  logic [NQ*DW-1:0] queue_data;
  logic [NQ-1:0]   pop;
  logic            consumed;
  logic            busy;
  logic            clear_stats;
  logic [NQ*CW-1:0] served_count;
  logic [NQ*CW-1:0] drop_count;
  logic            overlap_error;
  logic            drop_error;

  int n_cmp = 0;
  int n_err = 0;

  queue_dispatcher_if #(.DATA_WIDTH(DW)) mem_if ();

  queue_dispatcher #(
    .NUMBER_OF_QUEUES(NQ),
    .DATA_WIDTH      (DW),
    .COUNTER_WIDTH   (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sched_enable_i (sched_enable),
    .sched_id_i     (sched_id),
    .empty_i        (empty),
    .queue_data_i   (queue_data),
    .pop_o          (pop),
    .mem_if         (mem_if),
    .consumed_o     (consumed),
    .busy_o         (busy),
    .clear_stats_i  (clear_stats),
    .served_count_o (served_count),
    .drop_count_o   (drop_count),
    .overlap_error_o(overlap_error),
    .drop_error_o   (drop_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] served(input int q);
    return served_count[q*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] dropped(input int q);
    return drop_count[q*CW +: CW];
  endfunction

  // Full transfer with out_ready already high: grant, FETCH, SEND, ACK.
  task automatic xfer(input logic [1:0] id);
    sched_enable = 1'b1;
    sched_id     = id;
    tick();
    sched_enable = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    sched_enable     = 1'b0;
    sched_id         = '0;
    empty            = 4'b1000;
    queue_data       = {16'h3333, 16'hA5A5, 16'hB1B1, 16'h1111};
    clear_stats      = 1'b0;
    mem_if.out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_pop",      pop, 0);
    chk("rst_valid",    mem_if.out_valid, 0);
    chk("rst_data",     mem_if.out_data, 0);
    chk("rst_consumed", consumed, 0);
    chk("rst_busy",     busy, 0);
    chk("rst_served",   served_count, 0);
    chk("rst_drop",     drop_count, 0);
    chk("rst_ovl",      overlap_error, 0);
    chk("rst_derr",     drop_error, 0);
    reset = 1'b0;
    tick();

    // Basic transfer on queue 2
    sched_enable = 1'b1;
    sched_id     = 2'd2;
    tick();
    sched_enable = 1'b0;
    chk("basic_pop",    pop, 4'b0100);
    chk("basic_busy",   busy, 1);
    chk("basic_fvalid", mem_if.out_valid, 0);
    mem_if.out_ready = 1'b1;
    tick();
    chk("basic_valid",  mem_if.out_valid, 1);
    chk("basic_data",   mem_if.out_data, 16'hA5A5);
    chk("basic_pop0",   pop, 0);
    chk("basic_cons0",  consumed, 0);
    tick();
    chk("basic_cons",   consumed, 1);
    chk("basic_vlow",   mem_if.out_valid, 0);
    chk("basic_served", served(2), 1);
    tick();
    chk("basic_cons_end", consumed, 0);
    chk("basic_idle",     busy, 0);

    // Backpressure on queue 1
    mem_if.out_ready = 1'b0;
    sched_enable = 1'b1;
    sched_id     = 2'd1;
    tick();
    sched_enable = 1'b0;
    chk("bp_pop", pop, 4'b0010);
    tick();
    chk("bp_valid0", mem_if.out_valid, 1);
    chk("bp_data0",  mem_if.out_data, 16'hB1B1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", mem_if.out_valid, 1);
      chk("bp_data",  mem_if.out_data, 16'hB1B1);
      chk("bp_nopop", pop, 0);
      chk("bp_nocons", consumed, 0);
    end
    mem_if.out_ready = 1'b1;
    tick();
    chk("bp_cons",   consumed, 1);
    chk("bp_vlow",   mem_if.out_valid, 0);
    chk("bp_served", served(1), 1);
    tick();
    chk("bp_cons_end", consumed, 0);

    // Empty grant on queue 3
    sched_enable = 1'b1;
    sched_id     = 2'd3;
    tick();
    sched_enable = 1'b0;
    chk("emp_pop",   pop, 0);
    chk("emp_busy",  busy, 1);
    chk("emp_valid", mem_if.out_valid, 0);
    chk("emp_cons0", consumed, 0);
    tick();
    chk("emp_cons",  consumed, 1);
    chk("emp_valid2", mem_if.out_valid, 0);
    chk("emp_drop",  dropped(3), 1);
    chk("emp_derr",  drop_error, 1);
    tick();
    chk("emp_cons_end", consumed, 0);
    chk("emp_idle",     busy, 0);

    // Overlapping grant for queue 0 during SEND of queue 1
    mem_if.out_ready = 1'b0;
    sched_enable = 1'b1;
    sched_id     = 2'd1;
    tick();
    sched_enable = 1'b0;
    chk("ovl_pop1", pop, 4'b0010);
    tick();
    chk("ovl_ovl0", overlap_error, 0);
    sched_enable = 1'b1;
    sched_id     = 2'd0;
    tick();
    sched_enable = 1'b0;
    chk("ovl_ovl",   overlap_error, 1);
    chk("ovl_valid", mem_if.out_valid, 1);
    chk("ovl_data",  mem_if.out_data, 16'hB1B1);
    chk("ovl_nopop", pop, 0);
    mem_if.out_ready = 1'b1;
    tick();
    chk("ovl_cons",   consumed, 1);
    chk("ovl_served1", served(1), 2);
    chk("ovl_served0", served(0), 0);
    tick();
    chk("ovl_idle", busy, 0);

    // Saturation at 3 with 2-bit counters, then clear on a 6th increment
    for (int i = 0; i < 5; i++) begin
      xfer(2'd0);
    end
    chk("sat_served0", served(0), 3);
    sched_enable = 1'b1;
    sched_id     = 2'd0;
    tick();
    sched_enable = 1'b0;
    tick();
    chk("clr_valid", mem_if.out_valid, 1);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clr_served0", served(0), 0);
    chk("clr_all_served", served_count, 0);
    chk("clr_drop",    drop_count, 0);
    chk("clr_derr",    drop_error, 0);
    chk("clr_ovl",     overlap_error, 0);
    chk("clr_cons",    consumed, 1);
    tick();
    chk("clr_idle", busy, 0);

    // Reset while out_valid is high
    xfer(2'd2);
    chk("rs_pre_served", served(2), 1);
    mem_if.out_ready = 1'b0;
    sched_enable = 1'b1;
    sched_id     = 2'd2;
    tick();
    sched_enable = 1'b0;
    tick();
    chk("rs_valid_pre", mem_if.out_valid, 1);
    reset = 1'b1;
    tick();
    chk("rs_valid",  mem_if.out_valid, 0);
    chk("rs_cons",   consumed, 0);
    chk("rs_busy",   busy, 0);
    chk("rs_pop",    pop, 0);
    chk("rs_data",   mem_if.out_data, 0);
    chk("rs_served", served_count, 0);
    reset = 1'b0;
    mem_if.out_ready = 1'b1;
    tick();
    chk("rs_cons_after", consumed, 0);
    sched_enable = 1'b1;
    sched_id     = 2'd2;
    tick();
    sched_enable = 1'b0;
    chk("rs_fresh_pop", pop, 4'b0100);
    tick();
    chk("rs_fresh_valid", mem_if.out_valid, 1);
    chk("rs_fresh_data",  mem_if.out_data, 16'hA5A5);
    tick();
    chk("rs_fresh_cons",   consumed, 1);
    chk("rs_fresh_served", served(2), 1);
    tick();
    chk("rs_fresh_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/queue_dispatcher.md
# queue_dispatcher

Sequences the transfer of one request from the queue the scheduler selects to the downstream memory port. It consumes the scheduler's `enable`/`id` grant, pops exactly one entry from the granted first-word-fall-through (FWFT) queue, and drives it through a valid/ready handshake. It then returns a one-cycle `consumed` pulse that releases the scheduler's pending transaction. It also keeps per-queue served/dropped statistics and sticky protocol-error flags for the control registers.

## Interface
Parameters:
- NUMBER_OF_QUEUES, 4, number of request queues; ≥2
- DATA_WIDTH, 64, width of one queue entry
- COUNTER_WIDTH, 32, width of each statistics counter

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- sched_enable  in  1  one-cycle grant pulse from scheduler
- sched_id  in  $clog2(NUMBER_OF_QUEUES)  granted queue index, valid with sched_enable
- empty  in  NUMBER_OF_QUEUES  per-queue empty flags
- queue_data  in  NUMBER_OF_QUEUES×DATA_WIDTH  FWFT head entry of each queue
- pop  out  NUMBER_OF_QUEUES  one-hot read strobe to queues
- out_data  out  DATA_WIDTH  request to downstream port
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- consumed  out  1  completion pulse to scheduler
- busy  out  1  state ≠ IDLE
- clear_stats  in  1  clear counters and error flags
- served_count  out  NUMBER_OF_QUEUES×COUNTER_WIDTH  entries forwarded per queue
- drop_count  out  NUMBER_OF_QUEUES×COUNTER_WIDTH  grants to an empty queue, per queue
- overlap_error  out  1  sticky: grant received while busy
- drop_error  out  1  sticky: any grant found its queue empty

## Operation
- FSM states: IDLE, FETCH, SEND, ACK.
- IDLE:
  - On sched_enable, latch sched_id into cur_id and go to FETCH.
  - Otherwise stay.
- FETCH, if ~empty[cur_id]:
  - pop[cur_id]=1 for this single cycle.
  - Register out_data ← queue_data[cur_id].
  - Go to SEND.
- FETCH, if empty[cur_id]:
  - No pop.
  - drop_count[cur_id]++ and set drop_error.
  - Go to ACK. The scheduler is always released; it never hangs.
- SEND:
  - out_valid=1 and out_data held stable.
  - On out_ready, served_count[cur_id]++ and go to ACK.
- ACK:
  - consumed=1 for exactly this cycle.
  - Go to IDLE.
- consumed is 0 in every state except ACK. The scheduler detects its rising edge, so every ACK is separated by ≥1 low cycle.
- sched_enable while state≠IDLE:
  - Ignored, with no change to cur_id or the transfer in progress.
  - Sets overlap_error.
- Counters:
  - Saturate at 2^COUNTER_WIDTH−1; they never wrap.
  - clear_stats zeros all counters and both error flags next cycle.
  - clear_stats coinciding with an increment or error event: clear wins.
  - clear_stats does not affect the FSM.
- pop is one-hot or zero. It is never asserted outside FETCH.

## Timing
- Reset values:
  - State IDLE.
  - pop, out_valid, consumed, busy, overlap_error, drop_error = 0.
  - out_data and all counters = 0.
- Reset mid-operation: next cycle is IDLE with all outputs at their reset values. Any in-flight entry already popped is lost. No consumed is issued.
- Grant at cycle t (IDLE):
  - FETCH at t+1 with pop.
  - out_valid first high at t+2.
- With out_ready high at t+2:
  - Accept at t+2.
  - consumed at t+3.
  - IDLE at t+4, so the next grant is accepted at t+4.
- Minimum grant-to-grant spacing: 4 cycles.
- Empty-queue path: FETCH at t+1, consumed at t+2.
- out_valid never drops before out_ready is seen. out_data never changes while out_valid=1.
- Counters and flags update on the cycle after the event and are visible the following cycle.

## Test plan
- Basic transfer:
  - Stimulus: queue 2 non-empty with head 0xA5A5, grant id=2 at t, out_ready=1.
  - Required: pop=4'b0100 at t+1, out_valid with 0xA5A5 at t+2, consumed at t+3, served_count[2]=1.
- Backpressure:
  - Stimulus: grant id=1, out_ready=0 for 5 cycles.
  - Required: out_valid held 5 cycles with stable data, single pop, consumed exactly 1 cycle after the accepting cycle.
- Empty grant:
  - Stimulus: grant id=3 with empty[3]=1.
  - Required: no pop, no out_valid, consumed at t+2, drop_count[3]=1, drop_error=1.
- Overlap:
  - Stimulus: second grant id=0 during SEND of id=1.
  - Required: transfer of queue 1 completes unchanged, overlap_error=1, no pop of queue 0.
- Saturation/clear:
  - Stimulus: COUNTER_WIDTH=2 and 5 transfers on queue 0, then clear_stats in the same cycle as a 6th increment.
  - Required: served_count[0]=3 after the 5 transfers, then 0 after the clear.
- Reset mid-SEND:
  - Stimulus: assert reset while out_valid=1.
  - Required: next cycle out_valid=0, consumed=0, busy=0, counters=0. A fresh grant afterwards completes normally.
